// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard controller and its forwarding unit.
package pipeline_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } hz_state_e;

    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_W       = 2'b01;
    localparam logic [1:0] FWD_M       = 2'b10;
    localparam logic [1:0] RESULT_LOAD = 2'b01;

    // A producer only matters when it writes a real (nonzero) register that the consumer reads.
    function automatic logic reg_hit(input logic [4:0] rd, input logic we, input logic [4:0] rs);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

    // The M stage holds the younger result, so it wins over W.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] rd_m, input logic we_m,
                                           input logic [4:0] rd_w, input logic we_w);
        if (reg_hit(rd_m, we_m, rs)) begin
            return FWD_M;
        end else if (reg_hit(rd_w, we_w, rs)) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipeline_fwd_unit.sv
// Combinational operand forwarding selects for the two execute-stage sources.
module pipeline_fwd_unit
    import pipeline_pkg::*;
(
    input  logic [4:0] Ra1E,
    input  logic [4:0] Ra2E,
    input  logic [4:0] RdM,
    input  logic       RegWriteM,
    input  logic [4:0] RdW,
    input  logic       RegWriteW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE
);

    always_comb begin
        ForwardAE = fwd_sel(Ra1E, RdM, RegWriteM, RdW, RegWriteW);
        ForwardBE = fwd_sel(Ra2E, RdM, RegWriteM, RdW, RegWriteW);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stall/flush/forward controller with a watchdog-guarded multi-cycle wait.
// Build option: HAZARD_FORWARD_EN enables forwarding and load-use detection; otherwise RAW stalls.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int WDT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [4:0] Ra1D,
    input  logic [4:0] Ra2D,
    input  logic [4:0] Ra1E,
    input  logic [4:0] Ra2E,
    input  logic [4:0] RdE,
    input  logic       RegWriteE,
    input  logic [1:0] ResultSrcE,
    input  logic [4:0] RdM,
    input  logic       RegWriteM,
    input  logic [4:0] RdW,
    input  logic       RegWriteW,
    input  logic       PCSrcE,
    input  logic       mc_startE,
    input  logic       mc_done,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushD,
    output logic       FlushE,
    output logic       enE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       mc_timeout,
    output hz_state_e  dbg_state
);

    localparam int CNT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WDT_LAST = CNT_W'(WDT_CYCLES - 1);

    hz_state_e        state;
    hz_state_e        state_nxt;
    logic [CNT_W-1:0] wdt_cnt;
    logic [CNT_W-1:0] wdt_cnt_nxt;
    logic             data_hazard;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             mc_begin;
    logic             wdt_expired;

`ifdef HAZARD_FORWARD_EN
    // With forwarding, only a load feeding the next instruction must stall.
    assign data_hazard = (ResultSrcE == RESULT_LOAD) &&
                         (reg_hit(RdE, RegWriteE, Ra1D) || reg_hit(RdE, RegWriteE, Ra2D));

    pipeline_fwd_unit u_fwd (
        .Ra1E      (Ra1E),
        .Ra2E      (Ra2E),
        .RdM       (RdM),
        .RegWriteM (RegWriteM),
        .RdW       (RdW),
        .RegWriteW (RegWriteW),
        .ForwardAE (fwd_a),
        .ForwardBE (fwd_b)
    );
`else
    // Without forwarding, any pending write in E or M to a decode source must stall.
    assign data_hazard = reg_hit(RdE, RegWriteE, Ra1D) || reg_hit(RdE, RegWriteE, Ra2D) ||
                         reg_hit(RdM, RegWriteM, Ra1D) || reg_hit(RdM, RegWriteM, Ra2D);
    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;

    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{Ra1E, Ra2E, RdW, RegWriteW, ResultSrcE};
`endif

    // Multi-cycle handshake: mc_startE is held high while the operation sits in E;
    // the operation completes in the cycle mc_done is high, or when the watchdog expires.
    assign mc_begin    = mc_startE && !mc_done;
    assign wdt_expired = (wdt_cnt == WDT_LAST);
    assign dbg_state   = state;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= RUN;
            wdt_cnt <= '0;
        end else begin
            state   <= state_nxt;
            wdt_cnt <= wdt_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        wdt_cnt_nxt = wdt_cnt;
        case (state)
            RUN: begin
                if (mc_begin) begin
                    state_nxt   = MC_WAIT;
                    wdt_cnt_nxt = '0;
                end
            end
            MC_WAIT: begin
                if (mc_done || wdt_expired) begin
                    state_nxt   = RUN;
                    wdt_cnt_nxt = '0;
                end else begin
                    wdt_cnt_nxt = wdt_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt   = RUN;
                wdt_cnt_nxt = '0;
            end
        endcase
    end

    // Reset is folded into the output logic so the controls are quiet while n_rst is low,
    // even though they are otherwise combinational from the pipeline inputs.
    always_comb begin
        StallF     = 1'b0;
        StallD     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        enE        = 1'b1;
        mc_timeout = 1'b0;
        ForwardAE  = fwd_a;
        ForwardBE  = fwd_b;
        if (!n_rst) begin
            ForwardAE = FWD_RF;
            ForwardBE = FWD_RF;
        end else begin
            case (state)
                RUN: begin
                    if (mc_begin) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        enE    = 1'b0;
                    end else if (PCSrcE) begin
                        FlushD = 1'b1;
                        FlushE = 1'b1;
                    end else if (data_hazard) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end
                end
                MC_WAIT: begin
                    if (mc_done) begin
                        enE = 1'b1;
                    end else if (wdt_expired) begin
                        mc_timeout = 1'b1;
                    end else begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        enE    = 1'b0;
                    end
                end
                default: begin
                    enE = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter WDT_CYCLES, default 64: the maximum number of MC_WAIT cycles before a forced release.
REQ-002 SHALL have port clk  in  1: rising-edge clock.
REQ-003 SHALL have port n_rst  in  1: reset, asynchronous, active-low.
REQ-004 SHALL have ports Ra1D, Ra2D  in  5 each: decode-stage source registers.
REQ-005 SHALL have ports Ra1E, Ra2E, RdE  in  5 each: execute-stage source and destination registers.
REQ-006 SHALL have ports RegWriteE  in  1 and ResultSrcE  in  2; ResultSrcE == 2'b01 marks a load.
REQ-007 SHALL have ports RdM  in  5, RegWriteM  in  1, RdW  in  5, RegWriteW  in  1: memory- and writeback-stage destinations.
REQ-008 SHALL have port PCSrcE  in  1: taken branch or jump resolved in E.
REQ-009 SHALL have port mc_startE  in  1: a multi-cycle operation occupies E.
REQ-010 SHALL have port mc_done  in  1: the multi-cycle unit's result is valid this cycle.
REQ-011 SHALL have ports StallF, StallD  out  1 each: hold the PC and the F/D register.
REQ-012 SHALL have ports FlushD, FlushE  out  1 each: clear the F/D and D/E registers.
REQ-013 SHALL have port enE  out  1: enable to the D/E register (0 = hold).
REQ-014 SHALL have ports ForwardAE, ForwardBE  out  2 each: 00 register file, 01 W result, 10 M result.
REQ-015 SHALL have port mc_timeout  out  1: one-cycle pulse on a watchdog release.

Function
REQ-016 SHALL implement an FSM with exactly two states, RUN and MC_WAIT, plus a cycle counter wdt_cnt sized $clog2(WDT_CYCLES).
REQ-017 SHALL, in RUN, flag a load-use hazard when all of the following hold: ResultSrcE == 01, RegWriteE == 1, RdE != 0, and RdE equals Ra1D or Ra2D.
REQ-018 SHALL, on a load-use hazard in RUN with PCSrcE == 0, drive StallF = 1, StallD = 1 and FlushE = 1 combinationally in the same cycle.
REQ-019 SHALL, when PCSrcE == 1 in RUN, drive FlushD = 1 and FlushE = 1 and StallF = StallD = 0, overriding any load-use hazard.
REQ-020 SHALL, when mc_startE == 1 and mc_done == 0 in RUN, drive StallF = StallD = 1 and enE = 0 that cycle and enter MC_WAIT with wdt_cnt = 0.
REQ-021 SHALL, in MC_WAIT, drive StallF = StallD = 1, enE = 0 and FlushD = FlushE = 0, ignore PCSrcE, and increment wdt_cnt every cycle.
REQ-022 SHALL, in MC_WAIT with mc_done == 1, drop all stalls and drive enE = 1 in that same cycle, then return to RUN.
REQ-023 SHALL, in MC_WAIT when wdt_cnt == WDT_CYCLES-1 and mc_done == 0, pulse mc_timeout for one cycle, release stalls as in REQ-022, and return to RUN.
REQ-024 SHALL treat mc_startE == 1 with mc_done == 1 in RUN as a single-cycle operation: no stall and no state change.
REQ-025 SHALL drive enE = 1 and deassert all stall and flush outputs whenever no rule above applies.
REQ-026 SHALL set ForwardAE = 10 when RegWriteM == 1, RdM != 0 and RdM == Ra1E.
REQ-027 SHALL otherwise set ForwardAE = 01 when RegWriteW == 1, RdW != 0 and RdW == Ra1E, else 00.
REQ-028 SHALL compute ForwardBE the same way against Ra2E; an M-stage match SHALL take priority over a W-stage match.

Reset
REQ-029 SHALL, while n_rst == 0, force state = RUN, wdt_cnt = 0, mc_timeout = 0, StallF = StallD = FlushD = FlushE = 0, enE = 1 and ForwardAE = ForwardBE = 00.
REQ-030 SHALL, on reset asserted mid-MC_WAIT, abandon the wait immediately with no mc_timeout pulse.

Configuration
REQ-031 SHALL, when macro HAZARD_FORWARD_EN is defined, behave as in REQ-017 through REQ-028.
REQ-032 SHALL, when HAZARD_FORWARD_EN is undefined, tie ForwardAE and ForwardBE to 00.
REQ-033 SHALL, when HAZARD_FORWARD_EN is undefined, replace load-use detection with RAW detection: Ra1D or Ra2D equals a nonzero RdE with RegWriteE == 1, or a nonzero RdM with RegWriteM == 1; each RAW hazard stalls as in REQ-018.

Structure
REQ-034 SHALL place the state enum (RUN, MC_WAIT), the constants FWD_RF = 00, FWD_W = 01, FWD_M = 10 and RESULT_LOAD = 2'b01 in the shared package pipeline_pkg.
REQ-035 SHALL place the forwarding comparators in a combinational sub-module pipeline_fwd_unit, instantiated only under HAZARD_FORWARD_EN.

Verification
REQ-036 SHALL cover: load x5 in E (RdE = 5, ResultSrcE = 01) with Ra1D = 5 -> StallF = StallD = FlushE = 1 for exactly one cycle.
REQ-037 SHALL cover: RdM = 3 with RegWriteM = 1, RdW = 3 with RegWriteW = 1, Ra2E = 3 -> ForwardBE = 10; then RdM = 0 -> ForwardBE = 01.
REQ-038 SHALL cover: PCSrcE = 1 together with a load-use hazard -> FlushD = FlushE = 1, StallF = 0.
REQ-039 SHALL cover: mc_startE = 1 with mc_done asserted 4 cycles later -> enE = 0 for 4 cycles, enE = 1 in the done cycle, state back to RUN.
REQ-040 SHALL cover: mc_startE = 1 with mc_done never asserted and WDT_CYCLES = 8 -> mc_timeout pulses in MC_WAIT cycle 8 and the stalls release.
REQ-041 SHALL cover: n_rst asserted on MC_WAIT cycle 2 -> outputs take reset values immediately, mc_timeout = 0.
